// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed RV32I load/store front end for data_memory.
// Converts LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the
// memory's ctrl_mem_r/ctrl_mem_w interface. Sub-word stores use a
// read-modify-write sequence. Returns one response per accepted request.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  request handshake (accepted when both high at posedge)
//   req_we           1=store, 0=load
//   req_funct3       RV32I funct3 (size and sign)
//   req_addr         byte address
//   req_wdata        store data (low bytes for SB/SH)
//   resp_valid       one-cycle response strobe
//   resp_rdata       extended load data, 0 for stores and errors
//   resp_err         misaligned/invalid (or protected) request
//   mem_address      word address = req_addr[MEM_ADDR_W+1:2]
//   mem_w_data       write word
//   mem_r_data       read word (combinational from memory)
//   mem_ctrl_r       read enable
//   mem_ctrl_w       write enable
//
// Optional feature: define LSU_ROM_WRITE_PROTECT_EN to reject stores to
// word addresses below ROM_DEPTH with resp_err=1 and no memory access.

module load_store_unit #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int ROM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0]     mem_w_data,
    input  logic [DATA_W-1:0]     mem_r_data,
    output logic                  mem_ctrl_r,
    output logic                  mem_ctrl_w
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic                  we_q;
    logic [2:0]            f3_q;
    logic [MEM_ADDR_W+1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     word_q;

    logic                  accept;
    logic                  f3_ok;
    logic                  misalign;
    logic                  protect;
    logic                  req_err;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_W-1:0]     load_val;
    logic [DATA_W-1:0]     merged;

    // Address bits above the memory's word range are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:MEM_ADDR_W+2];

    localparam logic [MEM_ADDR_W-1:0] ROM_LIMIT = MEM_ADDR_W'(ROM_DEPTH);

    assign accept      = req_valid & req_ready;
    assign mem_address = addr_q[MEM_ADDR_W+1:2];
    assign mem_w_data  = word_q;

    // Request classification, evaluated on the raw inputs at accept time.
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~req_we;
            default:                f3_ok = 1'b0;
        endcase
        misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0])
                 | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
`ifdef LSU_ROM_WRITE_PROTECT_EN
        protect = req_we & (req_addr[MEM_ADDR_W+1:2] < ROM_LIMIT);
`else
        protect = 1'b0;
`endif
        req_err = ~f3_ok | misalign | protect;
    end

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        rd_byte  = mem_r_data[{addr_q[1:0], 3'b000} +: 8];
        rd_half  = addr_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
        load_val = mem_r_data;
        case (f3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'b0, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = mem_r_data;
        endcase
    end

    // Merge new byte/half into the word read back for SB/SH.
    always_comb begin
        merged = mem_r_data;
        if (f3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_ctrl_r = 1'b0;
        mem_ctrl_w = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_we)
                        state_d = LOAD;
                    else if (req_funct3[1:0] == 2'b10)
                        state_d = WRITE;
                    else
                        state_d = RMW_READ;
                end
            end
            LOAD: begin
                mem_ctrl_r = 1'b1;
                state_d    = RESP;
            end
            RMW_READ: begin
                mem_ctrl_r = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                mem_ctrl_w = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response registers only change on the edge entering RESP, so they
    // hold their value from one response to the next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            word_q     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[MEM_ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        word_q  <= req_wdata;
                        if (req_err) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata <= load_val;
                    resp_err   <= 1'b0;
                end
                RMW_READ: begin
                    word_q <= merged;
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    logic unused_we;
    assign unused_we = we_q;

endmodule
